// File: rtl/cpu_defs_pkg.sv
// Shared widths, constants, fetch FSM states and the FIFO entry layout.
package cpu_defs;

    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INST_WIDTH-1:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [ADDR_WIDTH-1:0] PC_INCR          = 32'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    // One buffered fetch result: 64 bits, pc in the upper half.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries; flush wins over push/pop.
module fetch_fifo
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC, fetch FSM, ROM access and decode handshake.
module if_fetch
    import cpu_defs::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  rom_ce,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [INST_WIDTH-1:0] rom_inst,
    input  logic                  branch_flag_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  id_ready,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t          state;
    fetch_state_t          next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CNT_W-1:0]      count;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;
    logic                  pop;
    logic                  has_room;
    logic                  fetch_en;

    assign pop      = if_valid & id_ready;
    assign has_room = (count < CNT_W'(FIFO_DEPTH)) | pop;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state and fetch enable; IDLE gives one quiet cycle after reset
    always_comb begin
        next_state = state;
        fetch_en   = 1'b0;
        case (state)
            IDLE:  next_state = FETCH;
            FETCH: fetch_en   = ~branch_flag_i & has_room;
        endcase
    end

    // Program counter: redirect beats sequential advance; low bits of target dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                pc <= RESET_PC;
        else if (branch_flag_i) pc <= branch_target_i & ~32'h3;
        else if (fetch_en)      pc <= pc + PC_INCR;
    end

    assign push_entry = '{pc: pc, inst: rom_inst};

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch_en),
        .pop       (pop),
        .flush     (branch_flag_i),
        .push_data (push_entry),
        .count     (count),
        .head      (head)
    );

    assign rom_ce   = fetch_en;
    assign rom_addr = pc;
    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? head.pc   : ZERO_WORD;
    assign if_inst  = if_valid ? head.inst : ZERO_WORD;

endmodule
